ram_arbiter: RTL

- Two-master arbiter and sequencer for the SoC's shared single-port 32-bit block RAM (2K words, byte write enables, one-cycle registered read).
- Master 0 is the CPU bus (valid/ready, picorv32-style). Master 1 is a second requester such as a video framebuffer fetch or DMA.
- Each access is sequenced through a 3-state FSM. Master 1 has fixed priority, bounded by a starvation limit that protects the CPU.

---
 rtl/ram_arbiter_if.sv | 59 +++++
 rtl/ram_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesting masters, the shared block RAM and
// the arbiter. The slave modport is the arbiter's view. The master modport
// is the environment's view: both masters plus the RAM read-data return.
//
// Handshake: a master raises valid with stable addr/wdata/wstrb and keeps
// them stable until it samples its ready high. ready is a single-cycle
// completion pulse. For reads, rdata is meaningful only while ready is high.
// wstrb == 4'b0000 marks a read; any other value is a byte-masked write.
interface ram_arbiter_if #(
   parameter int ADDR_W = 11
);

   // Master 0 (CPU bus)
   logic              m0_valid;
   logic [ADDR_W-1:0] m0_addr;
   logic [31:0]       m0_wdata;
   logic [3:0]        m0_wstrb;
   logic              m0_ready;
   logic [31:0]       m0_rdata;

   // Master 1 (video fetch / DMA)
   logic              m1_valid;
   logic [ADDR_W-1:0] m1_addr;
   logic [31:0]       m1_wdata;
   logic [3:0]        m1_wstrb;
   logic              m1_ready;
   logic [31:0]       m1_rdata;

   // Single-port block RAM
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   // One-hot owner of the access in flight, 00 when idle
   logic [1:0]        gnt;

   modport slave (
      input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
      output m0_ready, m0_rdata,
      input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
      output m1_ready, m1_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata,
      output gnt
   );

   modport master (
      output m0_valid, m0_addr, m0_wdata, m0_wstrb,
      input  m0_ready, m0_rdata,
      output m1_valid, m1_addr, m1_wdata, m1_wstrb,
      input  m1_ready, m1_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata,
      input  gnt
   );

endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter and sequencer for a shared single-port 32-bit block RAM.
//
// Every access walks IDLE -> ACCESS -> DONE, so one access costs three
// cycles. Arbitration happens only in IDLE: master 1 has fixed priority,
// but once master 0 has lost MAX_WAIT arbitrations in a row it is forced to
// win the next one. MAX_WAIT = 0 therefore makes master 0 always win.
//
// State encoding (visible on dbg_state): IDLE=0, ACCESS=1, DONE=2.
// dbg_wait_cnt shows the starvation counter.
module ram_arbiter #(
   parameter  int ADDR_W   = 11,
   parameter  int MAX_WAIT = 8,
   localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   ram_arbiter_if.slave     bus,
   output logic [1:0]       dbg_state,
   output logic [CNT_W-1:0] dbg_wait_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   state_t state;
   state_t state_next;

   // Registered outputs and their next values
   logic              ram_en_q,    ram_en_next;
   logic [3:0]        ram_we_q,    ram_we_next;
   logic [ADDR_W-1:0] ram_addr_q,  ram_addr_next;
   logic [31:0]       ram_wdata_q, ram_wdata_next;
   logic [1:0]        gnt_q,       gnt_next;
   logic              m0_ready_q,  m0_ready_next;
   logic              m1_ready_q,  m1_ready_next;
   logic [CNT_W-1:0]  wait_cnt,    wait_cnt_next;

   // Arbitration decision, meaningful only while in IDLE
   logic pick_m1;
   logic pick_m0;

   // Master 1 wins unless master 0 is also asking and has hit its loss limit.
   always_comb begin
      pick_m1 = bus.m1_valid && (!bus.m0_valid || (wait_cnt != MAX_CNT));
      pick_m0 = bus.m0_valid && !pick_m1;
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and next-output decode for the access sequencer.
   always_comb begin
      state_next     = state;
      ram_en_next    = 1'b0;
      ram_we_next    = 4'b0000;
      ram_addr_next  = ram_addr_q;
      ram_wdata_next = ram_wdata_q;
      gnt_next       = gnt_q;
      m0_ready_next  = 1'b0;
      m1_ready_next  = 1'b0;
      wait_cnt_next  = wait_cnt;

      unique case (state)
         IDLE: begin
            if (pick_m1) begin
               state_next     = ACCESS;
               ram_en_next    = 1'b1;
               ram_we_next    = bus.m1_wstrb;
               ram_addr_next  = bus.m1_addr;
               ram_wdata_next = bus.m1_wdata;
               gnt_next       = 2'b10;
               // A loss only counts when master 0 was actually waiting.
               if (bus.m0_valid && (wait_cnt != MAX_CNT)) begin
                  wait_cnt_next = wait_cnt + CNT_W'(1);
               end
            end else if (pick_m0) begin
               state_next     = ACCESS;
               ram_en_next    = 1'b1;
               ram_we_next    = bus.m0_wstrb;
               ram_addr_next  = bus.m0_addr;
               ram_wdata_next = bus.m0_wdata;
               gnt_next       = 2'b01;
               wait_cnt_next  = '0;
            end
         end

         ACCESS: begin
            // RAM samples en/we this cycle; read data lands next cycle,
            // which is exactly when the owner's ready is high.
            state_next    = DONE;
            m0_ready_next = gnt_q[0];
            m1_ready_next = gnt_q[1];
         end

         DONE: begin
            state_next = IDLE;
            gnt_next   = 2'b00;
         end

         default: begin
            state_next = IDLE;
            gnt_next   = 2'b00;
         end
      endcase
   end

   // Output and starvation-counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ram_en_q    <= 1'b0;
         ram_we_q    <= 4'b0000;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         gnt_q       <= 2'b00;
         m0_ready_q  <= 1'b0;
         m1_ready_q  <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         ram_en_q    <= ram_en_next;
         ram_we_q    <= ram_we_next;
         ram_addr_q  <= ram_addr_next;
         ram_wdata_q <= ram_wdata_next;
         gnt_q       <= gnt_next;
         m0_ready_q  <= m0_ready_next;
         m1_ready_q  <= m1_ready_next;
         wait_cnt    <= wait_cnt_next;
      end
   end

   // Drive the bus. Read data is shared combinationally; each master
   // qualifies it with its own ready.
   always_comb begin
      bus.ram_en    = ram_en_q;
      bus.ram_we    = ram_we_q;
      bus.ram_addr  = ram_addr_q;
      bus.ram_wdata = ram_wdata_q;
      bus.gnt       = gnt_q;
      bus.m0_ready  = m0_ready_q;
      bus.m1_ready  = m1_ready_q;
      bus.m0_rdata  = bus.ram_rdata;
      bus.m1_rdata  = bus.ram_rdata;
      dbg_state     = state;
      dbg_wait_cnt  = wait_cnt;
   end

endmodule
